// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master external memory bus arbiter.
package mem_bus_arbiter_pkg;

    // One cycle per state; every transaction walks the full sequence.
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACCESS,
        DATA,
        DONE
    } bus_state_t;

    typedef enum logic {
        CPU,
        AUX
    } bus_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, pad and status signals of the memory bus arbiter.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);

    logic              CpuReq;
    logic              CpuWrite;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWData;
    logic              CpuAck;

    logic              AuxReq;
    logic              AuxWrite;
    logic [ADDR_W-1:0] AuxAddr;
    logic [DATA_W-1:0] AuxWData;
    logic              AuxAck;

    logic [DATA_W-1:0] RData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              DataOutEn;
    logic [DATA_W-1:0] DataIn;
    logic              ALE;
    logic              ENB;
    logic              nME;
    logic              nOE;
    logic              nWE;
    logic              Busy;

    // Arbiter side.
    modport slave (
        input  CpuReq, CpuWrite, CpuAddr, CpuWData,
        input  AuxReq, AuxWrite, AuxAddr, AuxWData,
        input  DataIn,
        output CpuAck, AuxAck, RData, MemAddr, MemWData, DataOutEn,
        output ALE, ENB, nME, nOE, nWE, Busy
    );

    // Requester / environment side.
    modport master (
        output CpuReq, CpuWrite, CpuAddr, CpuWData,
        output AuxReq, AuxWrite, AuxAddr, AuxWData,
        output DataIn,
        input  CpuAck, AuxAck, RData, MemAddr, MemWData, DataOutEn,
        input  ALE, ENB, nME, nOE, nWE, Busy
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between CPU and auxiliary masters driving one
// asynchronous external memory through a fixed five-cycle strobe sequence.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic             Clock,
    input  logic             nReset,
    mem_bus_arbiter_if.slave bus
);

    bus_state_t        state;
    bus_state_t        stateNext;
    bus_owner_t        owner;
    bus_owner_t        lastGnt;
    bus_owner_t        grant;
    logic              granted;
    logic              latWrite;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latWData;
    logic [DATA_W-1:0] rData;

    assign bus.MemAddr  = latAddr;
    assign bus.MemWData = latWData;
    assign bus.RData    = rData;
    assign bus.Busy     = (state != IDLE);

    // Grant selection, next state and strobe decode from the current state.
    always_comb begin
        stateNext     = state;
        grant         = CPU;
        granted       = 1'b0;
        bus.ALE       = 1'b0;
        bus.ENB       = 1'b0;
        bus.nME       = 1'b1;
        bus.nOE       = 1'b1;
        bus.nWE       = 1'b1;
        bus.DataOutEn = 1'b0;
        bus.CpuAck    = 1'b0;
        bus.AuxAck    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.CpuReq && bus.AuxReq) begin
                    granted = 1'b1;
                    // Tie goes to whoever did not win last time.
                    grant   = (lastGnt == CPU) ? AUX : CPU;
                end else if (bus.CpuReq) begin
                    granted = 1'b1;
                    grant   = CPU;
                end else if (bus.AuxReq) begin
                    granted = 1'b1;
                    grant   = AUX;
                end
                if (granted) stateNext = ADDR;
            end
            ADDR: begin
                bus.ALE   = 1'b1;
                stateNext = ACCESS;
            end
            ACCESS: begin
                bus.nME = 1'b0;
                if (latWrite) begin
                    bus.nWE       = 1'b0;
                    bus.DataOutEn = 1'b1;
                end else begin
                    bus.nOE = 1'b0;
                end
                stateNext = DATA;
            end
            DATA: begin
                bus.nME = 1'b0;
                if (latWrite) begin
                    // nWE already released; keep driving data for hold time.
                    bus.DataOutEn = 1'b1;
                end else begin
                    bus.nOE = 1'b0;
                    bus.ENB = 1'b1;
                end
                stateNext = DONE;
            end
            DONE: begin
                bus.CpuAck = (owner == CPU);
                bus.AuxAck = (owner == AUX);
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register, operand latches, read capture and round-robin history.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            owner    <= CPU;
            lastGnt  <= AUX;
            latWrite <= 1'b0;
            latAddr  <= '0;
            latWData <= '0;
            rData    <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && granted) begin
                owner    <= grant;
                latWrite <= (grant == CPU) ? bus.CpuWrite : bus.AuxWrite;
                latAddr  <= (grant == CPU) ? bus.CpuAddr  : bus.AuxAddr;
                latWData <= (grant == CPU) ? bus.CpuWData : bus.AuxWData;
            end
            if (state == DATA && !latWrite) rData <= bus.DataIn;
            if (state == DONE) lastGnt <= owner;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic Clock  = 1'b0;
    logic nReset = 1'b1;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    // mPhase counts cycles since the grant (0 = no transaction in flight).
    int         mPhase;
    bit         mWrite;
    bus_owner_t mOwner;
    bus_owner_t mLast;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWData;
    logic [DW-1:0] mRData;

    function automatic bus_owner_t pickOwner(input logic c, input logic a, input bus_owner_t last);
        if (c && a) return (last == AUX) ? CPU : AUX;
        return c ? CPU : AUX;
    endfunction

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mPhase <= 0;
            mWrite <= 1'b0;
            mOwner <= CPU;
            mLast  <= AUX;
            mAddr  <= '0;
            mWData <= '0;
            mRData <= '0;
        end else if (mPhase == 0) begin
            if (bus.CpuReq || bus.AuxReq) begin
                mOwner <= pickOwner(bus.CpuReq, bus.AuxReq, mLast);
                if (pickOwner(bus.CpuReq, bus.AuxReq, mLast) == CPU) begin
                    mWrite <= bus.CpuWrite;
                    mAddr  <= bus.CpuAddr;
                    mWData <= bus.CpuWData;
                end else begin
                    mWrite <= bus.AuxWrite;
                    mAddr  <= bus.AuxAddr;
                    mWData <= bus.AuxWData;
                end
                mPhase <= 1;
            end
        end else begin
            if (mPhase == 3 && !mWrite) mRData <= bus.DataIn;
            if (mPhase == 4) begin
                mLast  <= mOwner;
                mPhase <= 0;
            end else begin
                mPhase <= mPhase + 1;
            end
        end
    end

    function automatic logic [56:0] expVec();
        logic busy, ale, enb, nme, noe, nwe, doe, cack, aack, mem, rd;
        busy = (mPhase != 0);
        mem  = (mPhase == 2) || (mPhase == 3);
        rd   = !mWrite;
        ale  = (mPhase == 1);
        enb  = rd && (mPhase == 3);
        nme  = !mem;
        noe  = !(rd && mem);
        nwe  = !(mWrite && mPhase == 2);
        doe  = mWrite && mem;
        cack = (mPhase == 4) && (mOwner == CPU);
        aack = (mPhase == 4) && (mOwner == AUX);
        return {busy, ale, enb, nme, noe, nwe, doe, cack, aack, mAddr, mWData, mRData};
    endfunction

    always @(negedge Clock) begin
        check("cycle_vs_model",
              {bus.Busy, bus.ALE, bus.ENB, bus.nME, bus.nOE, bus.nWE, bus.DataOutEn,
               bus.CpuAck, bus.AuxAck, bus.MemAddr, bus.MemWData, bus.RData},
              expVec());
    end

    // ---------------- directed stimulus ----------------
    task automatic clearReqs();
        bus.CpuReq = 1'b0;
        bus.AuxReq = 1'b0;
    endtask

    task automatic checkIdlePins(input string tag);
        check({tag, "_strobes"},
              {bus.Busy, bus.ALE, bus.ENB, bus.nME, bus.nOE, bus.nWE, bus.DataOutEn,
               bus.CpuAck, bus.AuxAck}, 9'b0_0_0_1_1_1_0_0_0);
        check({tag, "_regs"}, {bus.MemAddr, bus.MemWData, bus.RData}, 48'h0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int ackCyc[8];
        bus_owner_t ackWho[8];
        int nAck;
        int tieCyc;
        bus_owner_t tieWho;

        clearReqs();
        bus.CpuWrite = 1'b0; bus.CpuAddr = '0; bus.CpuWData = '0;
        bus.AuxWrite = 1'b0; bus.AuxAddr = '0; bus.AuxWData = '0;
        bus.DataIn   = '0;
        #1 nReset = 1'b0;
        #1 checkIdlePins("reset");
        repeat (2) @(posedge Clock);
        #2 nReset = 1'b1;

        // CPU read of 0x0040 returning 0xBEEF.
        @(posedge Clock); #2;
        bus.CpuReq = 1'b1; bus.CpuWrite = 1'b0; bus.CpuAddr = 16'h0040;
        bus.AuxAddr = 16'h7777; bus.DataIn = 16'hBEEF;
        @(negedge Clock); check("rd_c0_busy", bus.Busy, 1'b0);
        @(negedge Clock); check("rd_c1_ale", bus.ALE, 1'b1);
        check("rd_c1_addr", bus.MemAddr, 16'h0040);
        @(negedge Clock); check("rd_c2_noe_enb", {bus.nOE, bus.ENB}, 2'b00);
        @(negedge Clock); check("rd_c3_noe_enb", {bus.nOE, bus.ENB}, 2'b01);
        @(negedge Clock); check("rd_c4_acks", {bus.CpuAck, bus.AuxAck}, 2'b10);
        check("rd_c4_rdata", bus.RData, 16'hBEEF);
        #1 bus.CpuReq = 1'b0; bus.DataIn = 16'h0;

        // AUX write 0x1234 to 0x00FF.
        @(posedge Clock); #2;
        bus.AuxReq = 1'b1; bus.AuxWrite = 1'b1; bus.AuxAddr = 16'h00FF; bus.AuxWData = 16'h1234;
        @(negedge Clock);
        @(negedge Clock); check("wr_c1_nwe_doe", {bus.nWE, bus.DataOutEn}, 2'b10);
        check("wr_c1_regs", {bus.MemAddr, bus.MemWData}, 32'h00FF_1234);
        @(negedge Clock); check("wr_c2_nwe_doe_noe", {bus.nWE, bus.DataOutEn, bus.nOE}, 3'b011);
        @(negedge Clock); check("wr_c3_nwe_doe", {bus.nWE, bus.DataOutEn}, 2'b11);
        @(negedge Clock); check("wr_c4_acks", {bus.CpuAck, bus.AuxAck}, 2'b01);
        check("wr_c4_rdata_held", bus.RData, 16'hBEEF);
        #1 bus.AuxReq = 1'b0;

        // Both requesters held from reset: CPU, AUX, CPU, AUX at 5-cycle spacing.
        @(posedge Clock); #2 nReset = 1'b0;
        @(posedge Clock); #2 nReset = 1'b1;
        @(posedge Clock); #2;
        bus.CpuReq = 1'b1; bus.CpuWrite = 1'b0; bus.CpuAddr = 16'h0010;
        bus.AuxReq = 1'b1; bus.AuxWrite = 1'b0; bus.AuxAddr = 16'h0020;
        bus.DataIn = 16'h0A0A;
        nAck = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if ((bus.CpuAck || bus.AuxAck) && nAck < 8) begin
                ackCyc[nAck] = k;
                ackWho[nAck] = bus.CpuAck ? CPU : AUX;
                nAck++;
            end
        end
        #1 clearReqs();
        check("rr_ack_count", nAck, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nAck) begin
                check($sformatf("rr_ack%0d_cycle", i), ackCyc[i], 4 + 5 * i);
                check($sformatf("rr_ack%0d_owner", i), ackWho[i], (i % 2 == 0) ? CPU : AUX);
            end
        end

        // CPU drops Req and changes operands during ACCESS.
        @(posedge Clock); #2;
        bus.CpuReq = 1'b1; bus.CpuWrite = 1'b1; bus.CpuAddr = 16'h0100; bus.CpuWData = 16'hCAFE;
        repeat (3) @(negedge Clock);
        check("drop_c2_addr", bus.MemAddr, 16'h0100);
        #1 bus.CpuReq = 1'b0; bus.CpuAddr = 16'hFFFF; bus.CpuWData = 16'h0; bus.AuxAddr = 16'hEEEE;
        @(negedge Clock); check("drop_c3_regs", {bus.MemAddr, bus.MemWData}, 32'h0100_CAFE);
        @(negedge Clock); check("drop_c4_ack", bus.CpuAck, 1'b1);
        @(negedge Clock); check("drop_c5_busy", bus.Busy, 1'b0);

        // Reset during DATA of an AUX write.
        @(posedge Clock); #2;
        bus.AuxReq = 1'b1; bus.AuxWrite = 1'b1; bus.AuxAddr = 16'h0222; bus.AuxWData = 16'h5A5A;
        repeat (4) @(negedge Clock);
        check("rst_c3_doe_busy", {bus.DataOutEn, bus.Busy}, 2'b11);
        #1 nReset = 1'b0; bus.AuxReq = 1'b0;
        #1 checkIdlePins("rst_mid");
        @(posedge Clock); #2 nReset = 1'b1;
        nAck = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            if (bus.CpuAck || bus.AuxAck) nAck++;
        end
        check("rst_no_ack_after", nAck, 0);
        @(posedge Clock); #2;
        bus.CpuReq = 1'b1; bus.CpuWrite = 1'b0; bus.CpuAddr = 16'h0300;
        bus.AuxReq = 1'b1; bus.AuxWrite = 1'b0; bus.AuxAddr = 16'h0400;
        tieCyc = -1;
        tieWho = AUX;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (tieCyc < 0 && (bus.CpuAck || bus.AuxAck)) begin
                tieCyc = k;
                tieWho = bus.CpuAck ? CPU : AUX;
                #1 clearReqs();
            end
        end
        check("rst_tie_cycle", tieCyc, 4);
        check("rst_tie_owner", tieWho, CPU);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
